// File: rtl/usrt_pkg.sv
// usrt_pkg: shared USRT constants, FSM state type and parity-mode helper.
// RXPARITY_BREAK_EN adds the WAIT_IDLE state used by break detection.
package usrt_pkg;
  localparam int DATA_W = 8;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
`ifdef RXPARITY_BREAK_EN
    ST_STOP,
    ST_WAIT_IDLE
`else
    ST_STOP
`endif
  } rx_state_t;
  function automatic logic par_enabled(input logic [1:0] mode);
    return mode == PAR_ODD || mode == PAR_EVEN;
  endfunction
endpackage

// File: rtl/rxparity_if.sv
// rxparity_if: serial line, parity mode and host valid/ready bundle of the receiver.
interface rxparity_if;
  import usrt_pkg::*;
  logic              i_Rx;
  logic [1:0]        i_Parity;
  logic              i_Ready;
  logic [DATA_W-1:0] o_Data;
  logic              o_Valid;
  logic              o_Parity_Err;
  logic              o_Frame_Err;
  logic              o_Overrun;
  logic              o_Busy;
  logic              o_Break;
  modport master(
    output i_Rx, i_Parity, i_Ready,
    input  o_Data, o_Valid, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy, o_Break
  );
  modport slave(
    input  i_Rx, i_Parity, i_Ready,
    output o_Data, o_Valid, o_Parity_Err, o_Frame_Err, o_Overrun, o_Busy, o_Break
  );
endinterface

// File: rtl/parity_calc.sv
// parity_calc: expected parity bit for a data byte under the given parity mode.
module parity_calc
  import usrt_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        mode,
  output logic              par
);
  assign par = mode == PAR_ODD ? ~^data : mode == PAR_EVEN ? ^data : 1'b0;
endmodule

// File: rtl/rxparity.sv
// rxparity: serial frame receiver with parity/stop checking and a one-entry output buffer.
// RXPARITY_BREAK_EN enables break detection (all-zero frame) and the o_Break pulse.
module rxparity
  import usrt_pkg::*;
(
  input logic       i_Pclk,
  input logic       i_Rst_n,
  rxparity_if.slave bus
);
  rx_state_t         state, state_nx;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] shreg;
  logic [1:0]        mode;
  logic              par_bit, par_err, exp_par;
  logic              done, brk;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, pe_q, fe_q, ovr_q, brk_q;

  parity_calc u_par (.data(shreg), .mode(mode), .par(exp_par));

  always_ff @(posedge i_Pclk or negedge i_Rst_n)
    if (!i_Rst_n) state <= ST_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:      state_nx = bus.i_Rx ? ST_IDLE : ST_DATA;
      ST_DATA:      state_nx = cnt != 3'd7 ? ST_DATA : par_enabled(mode) ? ST_PARITY : ST_STOP;
      ST_PARITY:    state_nx = ST_STOP;
`ifdef RXPARITY_BREAK_EN
      ST_STOP:      state_nx = brk ? ST_WAIT_IDLE : ST_IDLE;
      ST_WAIT_IDLE: state_nx = bus.i_Rx ? ST_IDLE : ST_WAIT_IDLE;
`else
      ST_STOP:      state_nx = ST_IDLE;
`endif
      default:      state_nx = ST_IDLE;
    endcase
  end

  // A break needs every bit after the start to be 0; par_bit stays 0 in no-parity frames.
  always_comb begin
`ifdef RXPARITY_BREAK_EN
    brk = state == ST_STOP && !bus.i_Rx && shreg == '0 && !par_bit;
`else
    brk = 1'b0;
`endif
    done = state == ST_STOP && !brk;
  end

  always_ff @(posedge i_Pclk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      cnt     <= '0;
      shreg   <= '0;
      mode    <= PAR_NONE;
      par_bit <= 1'b0;
      par_err <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      if (state == ST_IDLE && !bus.i_Rx) begin
        cnt     <= '0;
        mode    <= bus.i_Parity;
        par_bit <= 1'b0;
        par_err <= 1'b0;
      end
      if (state == ST_DATA) begin
        shreg <= {bus.i_Rx, shreg[DATA_W-1:1]};
        cnt   <= cnt + 3'd1;
      end
      if (state == ST_PARITY) begin
        par_bit <= bus.i_Rx;
        par_err <= bus.i_Rx != exp_par;
      end
      ovr_q <= done && valid_q && !bus.i_Ready;
      brk_q <= brk;
      if (done && (!valid_q || bus.i_Ready)) begin
        data_q  <= shreg;
        pe_q    <= par_err;
        fe_q    <= !bus.i_Rx;
        valid_q <= 1'b1;
      end else if (valid_q && bus.i_Ready) valid_q <= 1'b0;
    end

  assign bus.o_Data       = data_q;
  assign bus.o_Valid      = valid_q;
  assign bus.o_Parity_Err = pe_q;
  assign bus.o_Frame_Err  = fe_q;
  assign bus.o_Overrun    = ovr_q;
  assign bus.o_Break      = brk_q;
  assign bus.o_Busy       = state != ST_IDLE;
endmodule
